hs_ram_arbiter: RTL and testbench

- Shares the single-port CPU work RAM between the running CPU and the hiscore save/restore engine.
- A hiscore request raises a pause request to the pause system and waits for pause acknowledgement, which means the CPU is frozen. It then waits a settle interval and performs one RAM access per request.
- While granted, RAM address, data and write-enable come from the hiscore engine. Otherwise they come from the CPU.
- The block sits between the core's work RAM, the hiscore controller and the pause module.

---
 rtl/hs_ram_arbiter.sv | 113 +++++++++++
 tb/tb_hs_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// Shares the CPU work RAM with the hiscore engine by pausing the CPU, settling, then muxing one access per request.
// Optional HS_ARB_TIMEOUT_EN: abandon a pause request that is never acknowledged and pulse hs_err.
module hs_ram_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  input  logic          hs_hold,
  output logic          hs_ack,
  output logic [DW-1:0] hs_dout,
  output logic          hs_err,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_SETTLE, S_ACCESS, S_WAIT, S_HELD} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       sel_q;
  logic       timeout_hit;

`ifdef HS_ARB_TIMEOUT_EN
  logic [9:0] tcnt_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)
      tcnt_q <= '0;
    else if (state_q == S_PAUSE && state_d == S_PAUSE)
      tcnt_q <= tcnt_q + 10'd1;
    else
      tcnt_q <= '0;
  end

  assign timeout_hit = (state_q == S_PAUSE) && hs_req && !pause_ack && (tcnt_q == 10'(TIMEOUT));
  assign hs_err      = timeout_hit;
`else
  // Without the timeout build PAUSE waits forever.
  assign timeout_hit = 1'b0 & (TIMEOUT > 0);
  assign hs_err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hs_ack  = 1'b0;
    case (state_q)
      S_IDLE:   if (hs_req) state_d = S_PAUSE;
      S_PAUSE: begin
        if (!hs_req)          state_d = S_IDLE;
        else if (pause_ack)   state_d = S_SETTLE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_SETTLE: begin
        if (!pause_ack)       state_d = S_PAUSE;
        else if (cnt_q == '0) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        hs_ack  = 1'b1;
        state_d = hs_hold ? S_HELD : S_IDLE;
      end
      S_HELD: begin
        // CPU is still frozen here, so a new request skips the settle interval.
        if (!hs_req && !hs_hold) state_d = S_IDLE;
        else if (!pause_ack)     state_d = S_PAUSE;
        else if (hs_req)         state_d = S_ACCESS;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      hs_dout <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= (state_d == S_ACCESS);
      if (state_q == S_PAUSE)
        cnt_q <= SETTLE_LOAD;
      else if (state_q == S_SETTLE && cnt_q != '0)
        cnt_q <= cnt_q - 4'd1;
      if (state_q == S_WAIT && !hs_we)
        hs_dout <= ram_dout;
    end
  end

  assign pause_req = (state_q != S_IDLE);
  assign ram_addr  = sel_q ? hs_addr : cpu_addr;
  assign ram_din   = sel_q ? hs_din  : cpu_din;
  assign ram_we    = sel_q ? hs_we   : cpu_we;
  assign cpu_dout  = ram_dout;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Bench for hs_ram_arbiter: CPU-path vector table, directed corner cases and randomized hiscore traffic
// checked against a RAM shadow and the request-to-ack latency rule.
module tb_hs_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int SETTLE = 4;
  localparam int TIMEOUT = 1023;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr, hs_addr, ram_addr;
  logic [DW-1:0] cpu_din, cpu_dout, hs_din, hs_dout, ram_din, ram_dout;
  logic          cpu_we, hs_req, hs_we, hs_hold, hs_ack, hs_err;
  logic          pause_req, pause_ack, ram_we;

  hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din), .hs_hold(hs_hold),
    .hs_ack(hs_ack), .hs_dout(hs_dout), .hs_err(hs_err),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous single-port RAM, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Reference model state: expected RAM contents and which addresses hold known data.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  logic [AW-1:0] wq[$];

  int n_vec = 0;
  int n_bad = 0;
  int pcnt = 0;
  int ack_dly = 0;
  bit ack_en = 1'b1;

  typedef struct {
    logic [AW-1:0] ca; logic [DW-1:0] cd; logic cw;
    logic [AW-1:0] ha; logic [DW-1:0] hd; logic hw;
    logic [AW-1:0] ea; logic [DW-1:0] ed; logic ew;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock; afterwards the pause responder acks once pause_req has been up for more than ack_dly cycles.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (pause_req) pcnt++; else pcnt = 0;
    pause_ack = ack_en && (pcnt > ack_dly);
  endtask

  task automatic note_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    if (!written[a]) begin written[a] = 1'b1; wq.push_back(a); end
  endtask

  task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic hold, input logic first, input int dly,
                           input logic pulse, input logic burst_chk);
    int  n, exp_lat;
    bit  got;
    ack_dly = dly;
    hs_we = we; hs_addr = a; hs_din = d; hs_hold = hold; hs_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (burst_chk) check("burst_pause_req", pause_req, 1);
      if (pulse && n == 1) begin
        cpu_addr = 11'h100; cpu_din = 8'hEE; cpu_we = 1'b1;
        #1;
        check("burst_ram_addr", ram_addr, a);
        check("burst_ram_we", ram_we, 1);
        cpu_we = 1'b0;
      end
      if (hs_ack) got = 1'b1;
    end
    exp_lat = first ? (1 + dly + SETTLE + 2) : 2;
    check("ack_latency", n, exp_lat);
    hs_req = 1'b0;
    tick();
    if (!we) check("hs_dout", hs_dout, ref_mem[a]);
    else note_write(a, d);
    check("pause_req_after_ack", pause_req, hold);
    check("single_ack", hs_ack, 0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    #1;
    check("cpu_wr_addr", ram_addr, a);
    tick();
    cpu_we = 1'b0;
    note_write(a, d);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{11'h123, 8'h5A, 1'b1, 11'h040, 8'h11, 1'b1, 11'h123, 8'h5A, 1'b1};
    vecs[1] = '{11'h100, 8'h77, 1'b1, 11'h7FF, 8'h00, 1'b0, 11'h100, 8'h77, 1'b1};
    vecs[2] = '{11'h040, 8'hC3, 1'b1, 11'h123, 8'hFF, 1'b1, 11'h040, 8'hC3, 1'b1};
    vecs[3] = '{11'h7FF, 8'hA5, 1'b0, 11'h000, 8'h3C, 1'b1, 11'h7FF, 8'hA5, 1'b0};
    vecs[4] = '{11'h000, 8'h81, 1'b1, 11'h555, 8'h42, 1'b0, 11'h000, 8'h81, 1'b1};
    vecs[5] = '{11'h2AA, 8'h00, 1'b0, 11'h7F0, 8'h99, 1'b1, 11'h2AA, 8'h00, 1'b0};

    reset = 1'b1; pause_ack = 1'b0;
    cpu_addr = 11'h3C3; cpu_din = 8'h12; cpu_we = 1'b0;
    hs_req = 1'b0; hs_we = 1'b0; hs_addr = 11'h055; hs_din = 8'h34; hs_hold = 1'b0;
    tick(); tick();
    check("rst_pause_req", pause_req, 0);
    check("rst_hs_ack", hs_ack, 0);
    check("rst_hs_err", hs_err, 0);
    check("rst_hs_dout", hs_dout, 0);
    check("rst_ram_addr", ram_addr, 11'h3C3);
    reset = 1'b0;
    tick();

    // CPU-only path: RAM follows the CPU in the same cycle.
    for (int i = 0; i < 6; i++) begin
      cpu_addr = vecs[i].ca; cpu_din = vecs[i].cd; cpu_we = vecs[i].cw;
      hs_addr = vecs[i].ha; hs_din = vecs[i].hd; hs_we = vecs[i].hw;
      #1;
      check("vec_ram", {ram_addr, ram_din, ram_we}, {vecs[i].ea, vecs[i].ed, vecs[i].ew});
      check("vec_pause_req", pause_req, 0);
      check("vec_cpu_dout", cpu_dout, ram_dout);
      tick();
      if (vecs[i].cw) note_write(vecs[i].ca, vecs[i].cd);
    end
    cpu_we = 1'b0;
    tick();

    // Single read of 0x040 (0xC3) with pause_ack 3 cycles after pause_req.
    do_access(1'b0, 11'h040, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0);

    // Burst write 0x01..0x04 to 0x7F0..0x7F3; CPU write pulses in ACCESS cycles are ignored.
    for (int k = 0; k < 4; k++)
      do_access(1'b1, 11'(11'h7F0 + k), 8'(k + 1), (k < 3), (k == 0), 2, (k > 0), 1'b1);

    // Cancel while waiting for pause_ack.
    ack_en = 1'b0;
    hs_we = 1'b1; hs_addr = 11'h123; hs_din = 8'hFF; hs_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cancel_pause_req", pause_req, 1);
      check("cancel_ram_we", ram_we, 0);
    end
    hs_req = 1'b0;
    tick();
    check("cancel_pause_drop", pause_req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cancel_no_ack", hs_ack, 0);
    end
    ack_en = 1'b1;

    // Reset asserted during the ACCESS cycle of a write to 0x100.
    ack_dly = 1;
    hs_we = 1'b1; hs_addr = 11'h100; hs_din = 8'h99; hs_hold = 1'b0; hs_req = 1'b1;
    for (int i = 0; i < 2 + 1 + SETTLE; i++) tick();
    check("rst_mid_access_sel", {ram_we, ram_addr}, {1'b1, 11'h100});
    cpu_addr = 11'h3AA; cpu_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_pause_req", pause_req, 0);
    check("rst_mid_ram", {ram_we, ram_addr}, {1'b0, 11'h3AA});
    check("rst_mid_ack", hs_ack, 0);
    hs_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", {hs_ack, pause_req}, 2'b00);
    end

    // Randomized traffic: CPU writes while idle, then hiscore bursts of 1..3 accesses.
    for (int t = 0; t < 40; t++) begin
      int nw, len;
      nw = $urandom_range(0, 2);
      for (int i = 0; i < nw; i++) cpu_write(11'($urandom), 8'($urandom));
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        logic          we;
        logic [AW-1:0] a;
        we = (wq.size() == 0) || ($urandom_range(0, 1) == 1);
        a  = we ? 11'($urandom) : wq[$urandom_range(0, wq.size() - 1)];
        cpu_addr = 11'($urandom); cpu_din = 8'($urandom);
        do_access(we, a, 8'($urandom), (k < len - 1), (k == 0), $urandom_range(0, 5), 1'b0, 1'b0);
      end
      check("rand_idle_pause_req", pause_req, 0);
    end

`ifdef HS_ARB_TIMEOUT_EN
    begin
      int n;
      bit seen;
      ack_en = 1'b0;
      hs_we = 1'b0; hs_addr = 11'h040; hs_hold = 1'b0; hs_req = 1'b1;
      n = 0; seen = 1'b0;
      while (!seen && n < TIMEOUT + 50) begin
        tick();
        n++;
        if (hs_ack) check("timeout_no_ack", hs_ack, 0);
        if (hs_err) seen = 1'b1;
      end
      check("timeout_err_cycle", n, TIMEOUT + 1);
      hs_req = 1'b0;
      tick();
      check("timeout_err_pulse", hs_err, 0);
      check("timeout_pause_drop", pause_req, 0);
      check("timeout_ack_after", hs_ack, 0);
      ack_en = 1'b1;
    end
`else
    check("err_tied_low", hs_err, 0);
`endif

    // RAM contents against the shadow model (covers blocked CPU writes and aborted accesses).
    foreach (wq[i]) check("mem", mem[wq[i]], ref_mem[wq[i]]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
